// File: rtl/hist2d_bin_accum_if.sv
// Hit-strobe and read-port bundle for the 2D IQ histogram accumulator.
// Handshake: no backpressure. The master asserts data_in or rd_en for one cycle per
// request with coordinates valid in that cycle. rd_valid marks the cycle rd_count is valid.
interface hist2d_bin_accum_if #(
  parameter int IW = 8,
  parameter int QW = 8,
  parameter int CW = 16
) ();
  logic          data_in;
  logic [IW-1:0] i_bin_coord;
  logic [QW-1:0] q_bin_coord;
  logic          rd_en;
  logic [IW-1:0] rd_i;
  logic [QW-1:0] rd_q;
  logic          rd_valid;
  logic [CW-1:0] rd_count;

  modport master (
    output data_in, i_bin_coord, q_bin_coord, rd_en, rd_i, rd_q,
    input  rd_valid, rd_count
  );

  modport slave (
    input  data_in, i_bin_coord, q_bin_coord, rd_en, rd_i, rd_q,
    output rd_valid, rd_count
  );
endinterface

// File: rtl/hist2d_bin_accum.sv
// 2D IQ histogram: saturating per-bin counters in a dual-port RAM, full-rate RMW with
// forwarding, hardware clear sweep, pipelined read-out port and hit statistics.
module hist2d_bin_accum #(
  parameter int IW = 8,
  parameter int QW = 8,
  parameter int CW = 16,
  parameter int TW = 32
) (
  input  logic          clk100,
  input  logic          rst,
  hist2d_bin_accum_if.slave bus,
  input  logic [IW-1:0] i_bin_num,
  input  logic [QW-1:0] q_bin_num,
  input  logic          clear_start,
  output logic          busy,
  output logic          saturated,
  output logic [TW-1:0] total_count,
  output logic [TW-1:0] dropped_count,
  output logic [0:0]    fsm_state
);
  localparam int AW    = IW + QW;
  localparam int DEPTH = 1 << AW;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [0:0]    state;
  logic [AW-1:0] clr_ptr;
  logic [CW-1:0] mem [DEPTH];
  logic [CW-1:0] ram_a_q, ram_b_q;

  logic          s1_valid, s2_valid, w3_valid;
  logic [AW-1:0] s1_addr, s2_addr, w3_addr;
  logic [CW-1:0] s2_data, w3_data;
  logic          rd_p1;

  logic          run, restart, i_ok, q_ok, accept, drop;
  logic [AW-1:0] hit_addr, rd_addr, wr_addr;
  logic          wr_en;
  logic [CW-1:0] wr_data, fwd_val, fwd_inc;
  logic          fwd_sat;

  assign run      = (state == ST_RUN);
  assign restart  = rst | clear_start;
  assign i_ok     = (i_bin_num == '0) || (bus.i_bin_coord < i_bin_num);
  assign q_ok     = (q_bin_num == '0) || (bus.q_bin_coord < q_bin_num);
  assign accept   = bus.data_in & run & i_ok & q_ok;
  assign drop     = bus.data_in & ~accept;
  assign hit_addr = {bus.q_bin_coord, bus.i_bin_coord};
  assign rd_addr  = {bus.rd_q, bus.rd_i};
  assign busy     = (state == ST_CLEAR);
  assign fsm_state = state;

  // The write port is shared: the sweep owns it in CLEAR, the RMW pipeline in RUN.
  assign wr_en   = (state == ST_CLEAR) | s2_valid;
  assign wr_addr = (state == ST_CLEAR) ? clr_ptr : s2_addr;
  assign wr_data = (state == ST_CLEAR) ? '0 : s2_data;

  always_ff @(posedge clk100) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    ram_a_q <= mem[hit_addr];
    ram_b_q <= mem[rd_addr];
  end

  // Older RAM data is patched with the two writes it cannot yet see; s2 is newest.
  always_comb begin
    fwd_val = ram_a_q;
    if (w3_valid && (w3_addr == s1_addr)) fwd_val = w3_data;
    if (s2_valid && (s2_addr == s1_addr)) fwd_val = s2_data;
    fwd_sat = (fwd_val == CNT_MAX);
    fwd_inc = fwd_sat ? CNT_MAX : fwd_val + CW'(1);
  end

  always_ff @(posedge clk100) begin
    if (restart) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else if (state == ST_CLEAR) begin
      clr_ptr <= clr_ptr + AW'(1);
      if (clr_ptr == '1) state <= ST_RUN;
    end
  end

  always_ff @(posedge clk100) begin
    if (restart) begin
      s1_valid      <= 1'b0;
      s1_addr       <= '0;
      s2_valid      <= 1'b0;
      s2_addr       <= '0;
      s2_data       <= '0;
      w3_valid      <= 1'b0;
      w3_addr       <= '0;
      w3_data       <= '0;
      saturated     <= 1'b0;
      total_count   <= '0;
      dropped_count <= '0;
      rd_p1         <= 1'b0;
      bus.rd_valid  <= 1'b0;
      bus.rd_count  <= '0;
    end else begin
      s1_valid <= accept;
      s1_addr  <= hit_addr;
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
      s2_data  <= fwd_inc;
      w3_valid <= s2_valid;
      w3_addr  <= s2_addr;
      w3_data  <= s2_data;
      if (s1_valid && fwd_sat) saturated <= 1'b1;
      if (accept) total_count   <= total_count + TW'(1);
      if (drop)   dropped_count <= dropped_count + TW'(1);
      rd_p1        <= bus.rd_en & run;
      bus.rd_valid <= rd_p1;
      if (rd_p1) bus.rd_count <= ram_b_q;
    end
  end
endmodule

// File: tb/tb_hist2d_bin_accum.sv
// Directed + randomized bench for hist2d_bin_accum on a small 8x8 histogram with 4-bit bins.
module tb_hist2d_bin_accum;
  localparam int IW = 3, QW = 3, CW = 4, TW = 16;
  localparam int DEPTH = 1 << (IW + QW);
  localparam int MAXV = (1 << CW) - 1;

  logic clk100 = 1'b0;
  logic rst, clear_start, busy, saturated;
  logic [IW-1:0] i_bin_num;
  logic [QW-1:0] q_bin_num;
  logic [TW-1:0] total_count, dropped_count;
  logic [0:0] fsm_state;

  always #5 clk100 = ~clk100;

  hist2d_bin_accum_if #(.IW(IW), .QW(QW), .CW(CW)) bus ();

  hist2d_bin_accum #(.IW(IW), .QW(QW), .CW(CW), .TW(TW)) dut (
    .clk100(clk100), .rst(rst), .bus(bus), .i_bin_num(i_bin_num), .q_bin_num(q_bin_num),
    .clear_start(clear_start), .busy(busy), .saturated(saturated),
    .total_count(total_count), .dropped_count(dropped_count), .fsm_state(fsm_state)
  );

  int total = 0, bad = 0;
  int model_bins[DEPTH];
  int m_total, m_dropped;
  bit m_sat, m_run;
  logic [CW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk100);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic model_zero();
    foreach (model_bins[k]) model_bins[k] = 0;
    m_total = 0; m_dropped = 0; m_sat = 0; m_run = 0;
  endtask

  // Reference rule for one strobe: range/run gate, then saturating bin increment.
  task automatic model_hit(input int i, input int q);
    int idx;
    if (m_run && (i_bin_num == 0 || i < int'(i_bin_num)) && (q_bin_num == 0 || q < int'(q_bin_num))) begin
      idx = q * (1 << IW) + i;
      if (model_bins[idx] == MAXV) m_sat = 1;
      else model_bins[idx]++;
      m_total++;
    end else begin
      m_dropped++;
    end
  endtask

  task automatic strobe(input int i, input int q);
    bus.data_in = 1'b1;
    bus.i_bin_coord = IW'(i);
    bus.q_bin_coord = QW'(q);
    model_hit(i, q);
    cyc();
    bus.data_in = 1'b0;
  endtask

  task automatic wait_sweep(input bit strobes);
    for (int k = 0; k < DEPTH; k++) begin
      check("busy_sweep", 32'(busy), 32'd1);
      check("rd_valid_in_clear", 32'(bus.rd_valid), 32'd0);
      bus.rd_en = (k == 3);
      bus.data_in = strobes && (k % 5 == 0);
      if (bus.data_in) begin
        bus.i_bin_coord = IW'($urandom_range(0, (1 << IW) - 1));
        bus.q_bin_coord = QW'($urandom_range(0, (1 << QW) - 1));
        model_hit(int'(bus.i_bin_coord), int'(bus.q_bin_coord));
      end
      cyc();
    end
    bus.data_in = 1'b0;
    bus.rd_en = 1'b0;
    check("busy_after_sweep", 32'(busy), 32'd0);
    m_run = 1;
  endtask

  task automatic check_zero_stats(input string tag);
    check({tag, "_total"}, 32'(total_count), 32'd0);
    check({tag, "_dropped"}, 32'(dropped_count), 32'd0);
    check({tag, "_sat"}, 32'(saturated), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic check_stats(input string tag);
    idle(4);
    check({tag, "_total"}, 32'(total_count), 32'(m_total & 'hFFFF));
    check({tag, "_dropped"}, 32'(dropped_count), 32'(m_dropped & 'hFFFF));
    check({tag, "_sat"}, 32'(saturated), 32'(m_sat));
  endtask

  task automatic read_one(input string tag, input int i, input int q);
    idle(4);
    bus.rd_en = 1'b1;
    bus.rd_i = IW'(i);
    bus.rd_q = QW'(q);
    cyc();
    bus.rd_en = 1'b0;
    cyc();
    check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    check({tag, "_count"}, 32'(bus.rd_count), 32'(model_bins[q * (1 << IW) + i]));
  endtask

  // Streams one read per cycle over every bin; results trail requests by two edges.
  task automatic read_all(input string tag);
    logic [CW-1:0] e;
    idle(4);
    for (int k = 0; k <= DEPTH; k++) begin
      bus.rd_en = (k < DEPTH);
      if (k < DEPTH) begin
        bus.rd_i = IW'(k % (1 << IW));
        bus.rd_q = QW'(k / (1 << IW));
        exp_q.push_back(CW'(model_bins[k]));
      end
      cyc();
      if (k >= 1) begin
        e = exp_q.pop_front();
        check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        check({tag, "_bin"}, 32'(bus.rd_count), 32'(e));
      end
    end
    bus.rd_en = 1'b0;
    cyc();
    check({tag, "_valid_idle"}, 32'(bus.rd_valid), 32'd0);
  endtask

  task automatic do_clear(input bit strobes);
    clear_start = 1'b1;
    bus.data_in = strobes;
    cyc();
    clear_start = 1'b0;
    bus.data_in = 1'b0;
    model_zero();
    check_zero_stats("clear_entry");
    wait_sweep(strobes);
  endtask

  initial begin
    rst = 1'b0; clear_start = 1'b0; i_bin_num = '0; q_bin_num = '0;
    bus.data_in = 1'b0; bus.i_bin_coord = '0; bus.q_bin_coord = '0;
    bus.rd_en = 1'b0; bus.rd_i = '0; bus.rd_q = '0;
    model_zero();

    // Reset and initial sweep.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_zero_stats("reset");
    check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("reset_rd_count", 32'(bus.rd_count), 32'd0);
    wait_sweep(1'b0);
    read_all("init_zero");

    // Spaced hits to one bin.
    for (int n = 0; n < 5; n++) begin
      strobe(3, 7);
      idle(5);
    end
    read_one("spaced_3_7", 3, 7);
    check_stats("spaced");

    // Back-to-back hits exercise both forwarding paths.
    for (int n = 0; n < 10; n++) strobe(1, 1);
    strobe(1, 2);
    read_one("b2b_1_1", 1, 1);
    read_one("b2b_1_2", 1, 2);
    check_stats("b2b");

    // Runtime I range limit.
    i_bin_num = IW'(4);
    strobe(4, 2);
    strobe(3, 2);
    check_stats("range");
    read_one("range_4_2", 4, 2);
    read_one("range_3_2", 3, 2);
    i_bin_num = '0;

    // Saturation, then clear.
    for (int n = 0; n < 17; n++) strobe(5, 5);
    read_one("sat_5_5", 5, 5);
    check_stats("sat");
    do_clear(1'b0);
    check_stats("after_clear");
    read_all("after_clear");

    // Clear in the middle of a burst, with strobes while busy.
    for (int n = 0; n < 8; n++) begin
      bus.data_in = 1'b1; bus.i_bin_coord = IW'(2); bus.q_bin_coord = QW'(3);
      model_hit(2, 3);
      cyc();
    end
    do_clear(1'b1);
    check_stats("mid_burst");
    read_all("mid_burst");

    // Randomized hits with changing range limits.
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) begin
        i_bin_num = IW'($urandom_range(0, (1 << IW) - 1));
        q_bin_num = QW'($urandom_range(0, (1 << QW) - 1));
      end
      if ($urandom_range(0, 9) < 7) strobe($urandom_range(0, (1 << IW) - 1), $urandom_range(0, (1 << QW) - 1));
      else cyc();
    end
    check_stats("random");
    read_all("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
